// File: rtl/vga_scan_gen_pkg.sv
// Shared timing defaults, pin bundle type and window-decode helper for the VGA scan generator.
package vga_scan_gen_pkg;

    localparam int unsigned CLK_DIV_DEF     = 4;
    localparam int unsigned H_TOTAL_DEF     = 800;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_ACT_START_DEF = 144;
    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned V_TOTAL_DEF     = 525;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_ACT_START_DEF = 35;
    localparam int unsigned V_ACTIVE_DEF    = 480;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic [11:0] rgb;
    } vga_pins_t;

    localparam vga_pins_t PINS_IDLE = '{hsync: 1'b1, vsync: 1'b1, rgb: 12'h000};

    // Half-open window test; 11-bit bounds so an end value of 1024 is representable.
    function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

endpackage

// File: rtl/vga_scan_gen_pix_en_gen.sv
// Pixel-rate prescaler: one-clk pix_en every CLK_DIV board clocks, plus a one-clk-early look-ahead.
module pix_en_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en,
    output logic pix_en_next
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] PRE  = DW'(CLK_DIV - 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q, pix_en_d;

    // Next-state for the divider and its registered terminal-count flag.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        pix_en_d = (div_cnt_d == LAST);
    end

    // Divider state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign pix_en_next = (div_cnt_q == PRE);

endmodule

// File: rtl/vga_scan_gen.sv
// 640x480 VGA raster generator: scan counters, visible-window decode, frame tick and
// registered, sync-aligned colour/sync pins.
module vga_scan_gen
    import vga_scan_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_ACT_START = H_ACT_START_DEF,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_ACT_START = V_ACT_START_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pix_rgb,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_tick,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB
);

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_W   = 10'(H_SYNC);
    localparam logic [9:0]  V_SYNC_W   = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS_LAST = 10'(V_ACT_START + V_ACTIVE - 1);
    localparam logic [10:0] H_LO       = 11'(H_ACT_START);
    localparam logic [10:0] H_HI       = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] V_LO       = 11'(V_ACT_START);
    localparam logic [10:0] V_HI       = 11'(V_ACT_START + V_ACTIVE);

    logic       pix_en_s, pix_en_next_s;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    vga_pins_t  pins_q, pins_d;
    logic       frame_tick_q, frame_tick_d;
    logic       bright_s, hs_raw_s, vs_raw_s;

    pix_en_gen #(.CLK_DIV(CLK_DIV)) u_pix_en_gen (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en_s),
        .pix_en_next (pix_en_next_s)
    );

    assign bright_s = in_window(hcount_q, H_LO, H_HI) && in_window(vcount_q, V_LO, V_HI);
    assign hs_raw_s = (hcount_q >= H_SYNC_W);
    assign vs_raw_s = (vcount_q >= V_SYNC_W);

    // Counter advance, output-stage capture and frame-tick look-ahead.
    always_comb begin
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        pins_d       = pins_q;
        frame_tick_d = 1'b0;
        if (pix_en_s) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d = 10'd0;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
                vcount_d = vcount_q;
            end
            pins_d.hsync = hs_raw_s;
            pins_d.vsync = vs_raw_s;
            pins_d.rgb   = bright_s ? pix_rgb : 12'h000;
        end else begin
            hcount_d = hcount_q;
            vcount_d = vcount_q;
            pins_d   = pins_q;
        end
        // Counters are frozen until the pix_en edge, so the tick can be registered one clk early.
        if (pix_en_next_s && (hcount_q == H_LAST) && (vcount_q == V_VIS_LAST)) begin
            frame_tick_d = 1'b1;
        end else begin
            frame_tick_d = 1'b0;
        end
    end

    // Scan state and pin registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_q     <= 10'd0;
            vcount_q     <= 10'd0;
            pins_q       <= PINS_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            pins_q       <= pins_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hCount     = hcount_q;
    assign vCount     = vcount_q;
    assign bright     = bright_s;
    assign pix_en     = pix_en_s;
    assign frame_tick = frame_tick_q;
    assign hSync      = pins_q.hsync;
    assign vSync      = pins_q.vsync;
    assign vgaR       = pins_q.rgb[11:8];
    assign vgaG       = pins_q.rgb[7:4];
    assign vgaB       = pins_q.rgb[3:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen on a reduced raster so several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_scan_gen;

    localparam int CD  = 4;
    localparam int HT  = 40;
    localparam int HS  = 6;
    localparam int HAS = 10;
    localparam int HA  = 24;
    localparam int VT  = 20;
    localparam int VS  = 2;
    localparam int VAS = 4;
    localparam int VA  = 12;
    localparam int FRAME_CLKS = CD * HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pix_rgb = 12'h000;
    logic [9:0]  hCount, vCount;
    logic        bright, pix_en, frame_tick, hSync, vSync;
    logic [3:0]  vgaR, vgaG, vgaB;

    int tests_run    = 0;
    int tests_failed = 0;
    bit src_follow   = 1'b0;

    // Reference model state: clock edges since reset release and the last sampled colour.
    int          t       = 0;
    logic [11:0] smp_rgb = 12'h000;

    vga_scan_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .pix_rgb(pix_rgb), .hCount(hCount), .vCount(vCount),
        .bright(bright), .pix_en(pix_en), .frame_tick(frame_tick), .hSync(hSync),
        .vSync(vSync), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) t <= 0;
        else      t <= t + 1;
        if (rst && (t % CD) == CD - 1) smp_rgb <= pix_rgb;
    end

    function automatic bit win(int h, int v);
        return (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
    endfunction

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !ok; i++) begin
            @(negedge clk);
            if (src_follow) pix_rgb = {hCount[3:0], vCount[3:0], 4'hA};
            if (pix_en === 1'b1 && hCount === 10'(h) && vCount === 10'(v)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [38:0] got;
        logic [38:0] exp_v;
        exp_v = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vgaR, vgaG, vgaB};
            tests_run++;
            if (got !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_state clk%0d: got %h, expected %h", i, got, exp_v);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_first_pix_en();
        for (int k = 1; k <= 2 * CD; k++) begin
            @(negedge clk);
            tests_run++;
            if (pix_en !== ((k % CD) == CD - 1)) begin
                tests_failed++;
                $display("FAIL first_pix_en edge%0d: got %b, expected %b", k, pix_en,
                         ((k % CD) == CD - 1));
            end
        end
    endtask

    task automatic test_model_random(input int n);
        int p, h, v, q, hq, vq;
        bit en, ehs, evs, eft, ebr;
        logic [11:0] ecol;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p  = t / CD;
            h  = p % HT;
            v  = (p / HT) % VT;
            en = (t % CD) == CD - 1;
            ebr = win(h, v);
            if (p == 0) begin
                ehs = 1'b1; evs = 1'b1; ecol = 12'h000;
            end else begin
                q  = p - 1;
                hq = q % HT;
                vq = (q / HT) % VT;
                ehs = hq >= HS;
                evs = vq >= VS;
                ecol = win(hq, vq) ? smp_rgb : 12'h000;
            end
            eft = en && (h == HT - 1) && (v == VAS + VA - 1);
            tests_run++;
            if (hCount !== 10'(h) || vCount !== 10'(v) || pix_en !== en || bright !== ebr ||
                hSync !== ehs || vSync !== evs || {vgaR, vgaG, vgaB} !== ecol ||
                frame_tick !== eft) begin
                tests_failed++;
                $display("FAIL model t=%0d: got h=%0d v=%0d en=%b br=%b hs=%b vs=%b rgb=%h ft=%b, expected h=%0d v=%0d en=%b br=%b hs=%b vs=%b rgb=%h ft=%b",
                         t, hCount, vCount, pix_en, bright, hSync, vSync, {vgaR, vgaG, vgaB},
                         frame_tick, h, v, en, ebr, ehs, evs, ecol, eft);
            end
            pix_rgb = 12'($urandom);
        end
    endtask

    task automatic test_line();
        bit ok;
        bit prev;
        int lows, falls;
        wait_pos(HT - 1, 0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL line_align: got timeout, expected (%0d,0)", HT - 1); end
        lows = 0; falls = 0; prev = hSync;
        for (int i = 0; i < HT; i++) begin
            repeat (CD) @(negedge clk);
            if (i == 0) begin
                tests_run++;
                if (hCount !== 10'd0 || vCount !== 10'd1) begin
                    tests_failed++;
                    $display("FAIL line_wrap: got (%0d,%0d), expected (0,1)", hCount, vCount);
                end
            end
            if (hSync === 1'b0) lows++;
            if (prev === 1'b1 && hSync === 1'b0) falls++;
            prev = hSync;
        end
        tests_run++;
        if (lows != HS) begin tests_failed++; $display("FAIL hsync_width: got %0d, expected %0d", lows, HS); end
        tests_run++;
        if (falls != 1) begin tests_failed++; $display("FAIL hsync_pulses: got %0d, expected 1", falls); end
        tests_run++;
        if (hCount !== 10'(HT - 1) || vCount !== 10'd1) begin
            tests_failed++;
            $display("FAIL line_period: got (%0d,%0d), expected (%0d,1)", hCount, vCount, HT - 1);
        end
    endtask

    task automatic test_frame();
        bit ok, seen;
        int nbright, vlows, fh, fv, lh, lv;
        wait_pos(HT - 1, VT - 1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL frame_align: got timeout, expected frame end"); end
        nbright = 0; vlows = 0; seen = 1'b0; fh = -1; fv = -1; lh = -1; lv = -1;
        for (int i = 0; i < HT * VT; i++) begin
            repeat (CD) @(negedge clk);
            if (bright === 1'b1) begin
                nbright++;
                if (!seen) begin fh = int'(hCount); fv = int'(vCount); seen = 1'b1; end
                lh = int'(hCount); lv = int'(vCount);
            end
            if (vSync === 1'b0) vlows++;
        end
        tests_run++;
        if (nbright != HA * VA) begin tests_failed++; $display("FAIL bright_count: got %0d, expected %0d", nbright, HA * VA); end
        tests_run++;
        if (fh != HAS || fv != VAS) begin tests_failed++; $display("FAIL bright_first: got (%0d,%0d), expected (%0d,%0d)", fh, fv, HAS, VAS); end
        tests_run++;
        if (lh != HAS + HA - 1 || lv != VAS + VA - 1) begin
            tests_failed++;
            $display("FAIL bright_last: got (%0d,%0d), expected (%0d,%0d)", lh, lv, HAS + HA - 1, VAS + VA - 1);
        end
        tests_run++;
        if (vlows != VS * HT) begin tests_failed++; $display("FAIL vsync_width: got %0d, expected %0d", vlows, VS * HT); end
    endtask

    task automatic test_colour();
        bit ok;
        int ph[8];
        int pv[8];
        logic [11:0] pe[8];
        ph = '{HAS + 3, HAS - 1, HAS, HAS + HA - 1, HAS + HA, HAS, HAS, 2};
        pv = '{VAS + 2, VAS, VAS, VAS + VA - 1, VAS + VA - 1, VAS - 1, VAS + VA, VAS + 3};
        pe = '{12'hD6A, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
        for (int k = 0; k < 8; k++) begin
            src_follow = (k == 0);
            if (k != 0) pix_rgb = 12'hFFF;
            wait_pos(ph[k], pv[k], ok);
            repeat (CD) @(negedge clk);
            tests_run++;
            if (!ok || {vgaR, vgaG, vgaB} !== pe[k]) begin
                tests_failed++;
                $display("FAIL colour_(%0d,%0d): got %h found=%b, expected %h", ph[k], pv[k],
                         {vgaR, vgaG, vgaB}, ok, pe[k]);
            end
        end
        src_follow = 1'b0;
    endtask

    task automatic test_frame_tick();
        bit ok, prev_tick;
        int nticks, last_c;
        wait_pos(HT - 1, VT - 1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL tick_align: got timeout, expected frame end"); end
        nticks = 0; last_c = -1; prev_tick = 1'b0;
        for (int c = 1; c <= 3 * FRAME_CLKS; c++) begin
            @(negedge clk);
            if (prev_tick) begin
                tests_run++;
                if (frame_tick !== 1'b0 || hCount !== 10'd0 || vCount !== 10'(VAS + VA)) begin
                    tests_failed++;
                    $display("FAIL tick_after: got ft=%b (%0d,%0d), expected ft=0 (0,%0d)",
                             frame_tick, hCount, vCount, VAS + VA);
                end
            end
            prev_tick = (frame_tick === 1'b1);
            if (frame_tick === 1'b1) begin
                nticks++;
                tests_run++;
                if (pix_en !== 1'b1 || hCount !== 10'(HT - 1) || vCount !== 10'(VAS + VA - 1)) begin
                    tests_failed++;
                    $display("FAIL tick_pos: got en=%b (%0d,%0d), expected en=1 (%0d,%0d)",
                             pix_en, hCount, vCount, HT - 1, VAS + VA - 1);
                end
                if (last_c >= 0) begin
                    tests_run++;
                    if (c - last_c != FRAME_CLKS) begin
                        tests_failed++;
                        $display("FAIL tick_spacing: got %0d, expected %0d", c - last_c, FRAME_CLKS);
                    end
                end
                last_c = c;
            end
        end
        tests_run++;
        if (nticks != 3) begin tests_failed++; $display("FAIL tick_count: got %0d, expected 3", nticks); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [38:0] got;
        logic [38:0] exp_v;
        exp_v = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        pix_rgb = 12'hFFF;
        wait_pos(20, 8, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL midreset_align: got timeout, expected (20,8)"); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        got = {hCount, vCount, bright, pix_en, frame_tick, hSync, vSync, vgaR, vgaG, vgaB};
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL midreset_state: got %h, expected %h", got, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_first_pix_en();
        test_model_random(2 * FRAME_CLKS);
        test_line();
        test_frame();
        test_colour();
        test_frame_tick();
        test_reset_mid();
        test_model_random(FRAME_CLKS + 50);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
